// File: rtl/dm_cache_ctrl.sv
// ---------------------------------------------------------------------------
// dm_cache_ctrl
// Direct-mapped, write-through, no-write-allocate cache controller placed
// between the processor datapath and a single-port data memory. Each line
// has its own valid bit. Read misses refill the whole line from memory, one
// word at a time. A flush command invalidates every line, one per cycle.
// Two saturating counters record hits and misses.
//
// Ports:
//   clk_100    system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   cpu_req    request strobe, sampled only while idle
//   cpu_we     1 = write, 0 = read
//   cpu_addr   word address
//   cpu_wdata  write data
//   cpu_rdata  read data, valid while cpu_done = 1
//   cpu_done   one-cycle completion pulse
//   cpu_hit    qualifies cpu_done: 1 = first lookup hit
//   cpu_busy   1 whenever the controller is not idle
//   flush      invalidate-all request (pulse)
//   mem_addr   memory word address
//   mem_wdata  memory write data
//   mem_rd     one-cycle memory read strobe
//   mem_wr     one-cycle memory write strobe
//   mem_rdata  memory read data, valid MEM_LAT cycles after mem_rd
//   hit_cnt    saturating hit counter
//   miss_cnt   saturating miss counter
// ---------------------------------------------------------------------------
module dm_cache_ctrl #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 2,
   parameter int MEM_LAT  = 4
) (
   input  logic              clk_100,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_hit,
   output logic              cpu_busy,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES = 1 << INDEX_W;
   localparam int WORDS = 1 << OFFSET_W;
   localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      FILL,
      INVAL
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                refill_q, refill_d;
   logic                pend_q, pend_d;
   logic [OFFSET_W-1:0] word_q, word_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [INDEX_W-1:0]  inval_q, inval_d;
   logic [LINES-1:0]    valid_q, valid_d;

   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                done_q, done_d;
   logic                hit_q, hit_d;
   logic                busy_q, busy_d;
   logic [ADDR_W-1:0]   maddr_q, maddr_d;
   logic [DATA_W-1:0]   mwdata_q, mwdata_d;
   logic                mrd_q, mrd_d;
   logic                mwr_q, mwr_d;
   logic [15:0]         hitcnt_q, hitcnt_d;
   logic [15:0]         misscnt_q, misscnt_d;

   // Tag and data storage, deliberately left out of reset; the valid bits
   // alone decide whether a line may be used.
   logic [TAG_W-1:0]    tagMem  [LINES];
   logic [DATA_W-1:0]   dataMem [LINES*WORDS];

   logic [TAG_W-1:0]            tagField;
   logic [INDEX_W-1:0]          lineIdx;
   logic [OFFSET_W-1:0]         wordOff;
   logic                        lookupHit;
   logic [DATA_W-1:0]           lookupWord;
   logic [OFFSET_W-1:0]         wordNext;
   logic                        dataWe;
   logic [INDEX_W+OFFSET_W-1:0] dataWaddr;
   logic [DATA_W-1:0]           dataWdata;
   logic                        tagWe;

   // Split the latched request address into tag / line index / word offset
   // and evaluate the hit condition against the current array contents.
   always_comb begin
      tagField   = addr_q[ADDR_W-1 -: TAG_W];
      lineIdx    = addr_q[OFFSET_W +: INDEX_W];
      wordOff    = addr_q[OFFSET_W-1:0];
      lookupHit  = valid_q[lineIdx] && (tagMem[lineIdx] == tagField);
      lookupWord = dataMem[{lineIdx, wordOff}];
      wordNext   = word_q + OFFSET_W'(1);
   end

   // Next-state and registered-output logic. Strobes and the done pulse
   // default low so they last exactly one cycle; address/data outputs hold.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      refill_d  = refill_q;
      pend_d    = pend_q;
      word_d    = word_q;
      lat_d     = lat_q;
      inval_d   = inval_q;
      valid_d   = valid_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      hit_d     = 1'b0;
      maddr_d   = maddr_q;
      mwdata_d  = mwdata_q;
      mrd_d     = 1'b0;
      mwr_d     = 1'b0;
      hitcnt_d  = hitcnt_q;
      misscnt_d = misscnt_q;
      dataWe    = 1'b0;
      dataWaddr = {lineIdx, wordOff};
      dataWdata = wdata_q;
      tagWe     = 1'b0;

      // A flush that arrives while busy is remembered until the next idle cycle.
      if (flush && (state_q != IDLE)) begin
         pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (flush || pend_q) begin
               pend_d  = 1'b0;
               inval_d = '0;
               state_d = INVAL;
            end else if (cpu_req) begin
               addr_d   = cpu_addr;
               we_d     = cpu_we;
               wdata_d  = cpu_wdata;
               refill_d = 1'b0;
               state_d  = LOOKUP;
            end
         end

         LOOKUP: begin
            // The second lookup after a refill must not count the request again.
            if (!refill_q) begin
               if (lookupHit) begin
                  if (hitcnt_q != 16'hFFFF) hitcnt_d = hitcnt_q + 16'd1;
               end else begin
                  if (misscnt_q != 16'hFFFF) misscnt_d = misscnt_q + 16'd1;
               end
            end
            if (we_q) begin
               dataWe   = lookupHit;
               mwr_d    = 1'b1;
               maddr_d  = addr_q;
               mwdata_d = wdata_q;
               done_d   = 1'b1;
               hit_d    = lookupHit && !refill_q;
               state_d  = IDLE;
            end else if (lookupHit) begin
               rdata_d = lookupWord;
               done_d  = 1'b1;
               hit_d   = !refill_q;
               state_d = IDLE;
            end else begin
               valid_d[lineIdx] = 1'b0;
               word_d  = '0;
               lat_d   = '0;
               mrd_d   = 1'b1;
               maddr_d = {tagField, lineIdx, {OFFSET_W{1'b0}}};
               state_d = FILL;
            end
         end

         FILL: begin
            // lat_q counts cycles since this word's strobe; the word is
            // captured in the cycle where the memory data becomes valid.
            if (lat_q == LAT_W'(MEM_LAT)) begin
               dataWe    = 1'b1;
               dataWaddr = {lineIdx, word_q};
               dataWdata = mem_rdata;
               lat_d     = '0;
               if (word_q == OFFSET_W'(WORDS - 1)) begin
                  tagWe            = 1'b1;
                  valid_d[lineIdx] = 1'b1;
                  refill_d         = 1'b1;
                  state_d          = LOOKUP;
               end else begin
                  word_d  = wordNext;
                  mrd_d   = 1'b1;
                  maddr_d = {tagField, lineIdx, wordNext};
               end
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end

         INVAL: begin
            valid_d[inval_q] = 1'b0;
            if (inval_q == INDEX_W'(LINES - 1)) begin
               state_d = IDLE;
            end else begin
               inval_d = inval_q + INDEX_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // Control state and registered outputs; reset aborts any fill in flight.
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         refill_q  <= 1'b0;
         pend_q    <= 1'b0;
         word_q    <= '0;
         lat_q     <= '0;
         inval_q   <= '0;
         valid_q   <= '0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         hit_q     <= 1'b0;
         busy_q    <= 1'b0;
         maddr_q   <= '0;
         mwdata_q  <= '0;
         mrd_q     <= 1'b0;
         mwr_q     <= 1'b0;
         hitcnt_q  <= '0;
         misscnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         refill_q  <= refill_d;
         pend_q    <= pend_d;
         word_q    <= word_d;
         lat_q     <= lat_d;
         inval_q   <= inval_d;
         valid_q   <= valid_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         hit_q     <= hit_d;
         busy_q    <= busy_d;
         maddr_q   <= maddr_d;
         mwdata_q  <= mwdata_d;
         mrd_q     <= mrd_d;
         mwr_q     <= mwr_d;
         hitcnt_q  <= hitcnt_d;
         misscnt_q <= misscnt_d;
      end
   end

   // Array writes: write hits, refill words and the tag at the end of a fill.
   always_ff @(posedge clk_100) begin
      if (dataWe) begin
         dataMem[dataWaddr] <= dataWdata;
      end
      if (tagWe) begin
         tagMem[lineIdx] <= tagField;
      end
   end

   assign cpu_rdata = rdata_q;
   assign cpu_done  = done_q;
   assign cpu_hit   = hit_q;
   assign cpu_busy  = busy_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = mwdata_q;
   assign mem_rd    = mrd_q;
   assign mem_wr    = mwr_q;
   assign hit_cnt   = hitcnt_q;
   assign miss_cnt  = misscnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_cache_ctrl
// Directed bench for dm_cache_ctrl with default parameters. A small memory
// model answers every read strobe with data equal to the strobed address,
// exactly MEM_LAT cycles later. Each step drives one request and compares
// latency, data, hit flag, write strobe and counters with hand-computed values.
// ---------------------------------------------------------------------------
module tb_dm_cache_ctrl;

   localparam int MEM_LAT = 4;

   logic        clk_100;
   logic        rst_n;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_done;
   logic        cpu_hit;
   logic        cpu_busy;
   logic        flush;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_rdata;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int          errors;
   int          checks;
   int          overlap;
   int          memCnt;
   logic [15:0] memPend;
   logic [15:0] rdAddrs[$];

   int          obsLat;
   logic [15:0] obsRdata;
   logic        obsHit;
   logic        obsWr;
   logic [15:0] obsWrAddr;
   logic [15:0] obsWrData;

   dm_cache_ctrl #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .INDEX_W (6),
      .OFFSET_W(2),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk_100  (clk_100),
      .rst_n    (rst_n),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_done (cpu_done),
      .cpu_hit  (cpu_hit),
      .cpu_busy (cpu_busy),
      .flush    (flush),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .mem_rdata(mem_rdata),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   // 100 MHz clock.
   initial clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   // Memory model and strobe monitor, evaluated mid-cycle. A read strobe seen
   // in cycle s makes the strobed address appear on mem_rdata during cycle
   // s+MEM_LAT only; every other cycle carries a recognisable junk value.
   initial begin
      memCnt    = 0;
      memPend   = 16'h0000;
      overlap   = 0;
      mem_rdata = 16'hDEAD;
   end
   always @(negedge clk_100) begin
      if (mem_rd && mem_wr) overlap++;
      if (mem_rd) begin
         rdAddrs.push_back(mem_addr);
         memPend   = mem_addr;
         memCnt    = MEM_LAT;
         mem_rdata = 16'hDEAD;
      end else if (memCnt > 0) begin
         memCnt--;
         mem_rdata = (memCnt == 0) ? memPend : 16'hDEAD;
      end else begin
         mem_rdata = 16'hDEAD;
      end
   end

   // One comparison: counts it, and on a mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request once the controller is idle, then wait (bounded) for
   // cpu_done. Latency is counted from the cycle the request is sampled.
   // A flush pulse is injected in cycle flushAt when flushAt > 0.
   task automatic applyStimulus(input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata, input int flushAt);
      int guard;
      guard = 0;
      @(negedge clk_100);
      while (cpu_busy && guard < 300) begin
         @(negedge clk_100);
         guard++;
      end
      rdAddrs.delete();
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      obsLat    = 0;
      @(negedge clk_100);
      cpu_req = 1'b0;
      obsLat  = 1;
      while (!cpu_done && obsLat < 200) begin
         @(negedge clk_100);
         obsLat++;
         flush = (obsLat == flushAt);
      end
      flush     = 1'b0;
      obsRdata  = cpu_rdata;
      obsHit    = cpu_hit;
      obsWr     = mem_wr;
      obsWrAddr = mem_addr;
      obsWrData = mem_wdata;
   endtask

   initial begin
      int busyCycles;
      int doneSeen;
      int nHits;
      int guard;

      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_wdata = 16'h0000;
      flush     = 1'b0;

      // Reset state.
      #22;
      checkOutput("rst_busy", cpu_busy, 0);
      checkOutput("rst_done", cpu_done, 0);
      checkOutput("rst_memrd", mem_rd, 0);
      checkOutput("rst_memwr", mem_wr, 0);
      checkOutput("rst_hitcnt", hit_cnt, 0);
      checkOutput("rst_misscnt", miss_cnt, 0);
      @(negedge clk_100);
      rst_n = 1'b1;

      // Cold read miss: whole line fetched, done at cycle 3 + 4*5 = 23.
      applyStimulus(1'b0, 16'h1234, 16'h0000, 0);
      checkOutput("miss_lat", obsLat, 23);
      checkOutput("miss_rdata", obsRdata, 16'h1234);
      checkOutput("miss_hit", obsHit, 0);
      checkOutput("miss_cnt1", miss_cnt, 1);
      checkOutput("fill_nstrobe", rdAddrs.size(), 4);
      for (int i = 0; i < 4 && i < rdAddrs.size(); i++) begin
         checkOutput("fill_addr", rdAddrs[i], 16'h1234 + 16'(i));
      end

      // Read hit on the resident line.
      applyStimulus(1'b0, 16'h1236, 16'h0000, 0);
      checkOutput("hit_lat", obsLat, 2);
      checkOutput("hit_rdata", obsRdata, 16'h1236);
      checkOutput("hit_hit", obsHit, 1);
      checkOutput("hit_cnt1", hit_cnt, 1);
      checkOutput("hit_nostrobe", rdAddrs.size(), 0);

      // Write hit: write-through strobe and line update.
      applyStimulus(1'b1, 16'h1235, 16'hBEEF, 0);
      checkOutput("wrhit_lat", obsLat, 2);
      checkOutput("wrhit_hit", obsHit, 1);
      checkOutput("wrhit_memwr", obsWr, 1);
      checkOutput("wrhit_addr", obsWrAddr, 16'h1235);
      checkOutput("wrhit_data", obsWrData, 16'hBEEF);
      applyStimulus(1'b0, 16'h1235, 16'h0000, 0);
      checkOutput("rdback_rdata", obsRdata, 16'hBEEF);
      checkOutput("rdback_hit", obsHit, 1);
      checkOutput("hit_cnt3", hit_cnt, 3);

      // Write miss: memory written, no allocation.
      applyStimulus(1'b1, 16'h4000, 16'h5A5A, 0);
      checkOutput("wrmiss_lat", obsLat, 2);
      checkOutput("wrmiss_hit", obsHit, 0);
      checkOutput("wrmiss_memwr", obsWr, 1);
      checkOutput("wrmiss_addr", obsWrAddr, 16'h4000);
      checkOutput("wrmiss_data", obsWrData, 16'h5A5A);
      checkOutput("miss_cnt2", miss_cnt, 2);
      applyStimulus(1'b0, 16'h4000, 16'h0000, 0);
      checkOutput("noalloc_lat", obsLat, 23);
      checkOutput("noalloc_hit", obsHit, 0);
      checkOutput("noalloc_rdata", obsRdata, 16'h4000);
      checkOutput("miss_cnt3", miss_cnt, 3);

      // Flush together with a request: request dropped, 64 busy cycles.
      @(negedge clk_100);
      flush    = 1'b1;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h1234;
      @(negedge clk_100);
      flush      = 1'b0;
      cpu_req    = 1'b0;
      busyCycles = 0;
      doneSeen   = 0;
      while (cpu_busy && busyCycles < 200) begin
         busyCycles++;
         if (cpu_done) doneSeen++;
         @(negedge clk_100);
      end
      checkOutput("flush_busy", busyCycles, 64);
      checkOutput("flush_nodone", doneSeen, 0);
      checkOutput("flush_hitcnt", hit_cnt, 3);
      checkOutput("flush_misscnt", miss_cnt, 3);
      applyStimulus(1'b0, 16'h1234, 16'h0000, 0);
      checkOutput("postflush_lat", obsLat, 23);
      checkOutput("postflush_hit", obsHit, 0);
      checkOutput("miss_cnt4", miss_cnt, 4);

      // Flush during a fill: fill finishes, then the invalidate runs.
      applyStimulus(1'b0, 16'h2000, 16'h0000, 6);
      checkOutput("fillflush_lat", obsLat, 23);
      checkOutput("fillflush_rdata", obsRdata, 16'h2000);
      @(negedge clk_100);
      checkOutput("fillflush_inval", cpu_busy, 1);
      applyStimulus(1'b0, 16'h2000, 16'h0000, 0);
      checkOutput("fillflush_remiss", obsLat, 23);
      checkOutput("miss_cnt6", miss_cnt, 6);

      // Reset in the middle of a fill (second word strobe in flight).
      @(negedge clk_100);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h3000;
      @(negedge clk_100);
      cpu_req = 1'b0;
      repeat (6) @(negedge clk_100);
      checkOutput("prerst_memrd", mem_rd, 1);
      checkOutput("prerst_addr", mem_addr, 16'h3001);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_memrd", mem_rd, 0);
      checkOutput("midrst_busy", cpu_busy, 0);
      checkOutput("midrst_addr", mem_addr, 0);
      checkOutput("midrst_misscnt", miss_cnt, 0);
      @(negedge clk_100);
      rst_n = 1'b1;
      applyStimulus(1'b0, 16'h3000, 16'h0000, 0);
      checkOutput("postrst_lat", obsLat, 23);
      checkOutput("postrst_rdata", obsRdata, 16'h3000);
      checkOutput("postrst_misscnt", miss_cnt, 1);

      // Saturate the hit counter with back-to-back hits.
      @(negedge clk_100);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h3001;
      nHits    = 0;
      guard    = 0;
      while (nHits < 65535 && guard < 140000) begin
         @(negedge clk_100);
         guard++;
         if (cpu_done) begin
            nHits++;
            if (nHits == 65535) cpu_req = 1'b0;
         end
      end
      cpu_req = 1'b0;
      checkOutput("sat_nhits", nHits, 65535);
      checkOutput("sat_hitcnt", hit_cnt, 16'hFFFF);
      applyStimulus(1'b0, 16'h3002, 16'h0000, 0);
      checkOutput("sat_hit", obsHit, 1);
      checkOutput("sat_rdata", obsRdata, 16'h3002);
      checkOutput("sat_hold", hit_cnt, 16'hFFFF);
      checkOutput("sat_misscnt", miss_cnt, 1);

      checkOutput("strobe_overlap", overlap, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
